// File: rtl/serial_alu_if.sv
// Start/done operation bus of the serial ALU: operands and controls in, result and status flags out.
interface serial_alu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ainv;
    logic             binv;
    logic [1:0]       select;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             zero;

    modport master (
        output start, a, b, ainv, binv, select,
        input  busy, done, result, cout, overflow, zero
    );

    modport slave (
        input  start, a, b, ainv, binv, select,
        output busy, done, result, cout, overflow, zero
    );
endinterface

// File: rtl/serial_alu.sv
// Digit-serial ALU: AND/OR/ADD/SLT over WIDTH bits, DIGIT bits per clock, carry rippled through a register.
// Latency N+1 edges from the accepting edge (N = WIDTH/DIGIT); start is ignored while busy.
module serial_alu #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 1
) (
    input  logic         clk,
    input  logic         rst,
    serial_alu_if.slave  bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh;
    logic             ainv_r, binv_r, carry_r;
    logic [1:0]       sel_r;
    logic [WIDTH-1:0] result_r;
    logic             cout_r, ovf_r, busy_r, done_r;

    logic [DIGIT-1:0] ad, bd, s, dsel;
    logic             cy, cin_msb, set;
    logic [WIDTH-1:0] res_next, res_final;

    // One digit of the slice: carry walks LSB to MSB within the digit.
    always_comb begin
        ad      = a_sh[DIGIT-1:0] ^ {DIGIT{ainv_r}};
        bd      = b_sh[DIGIT-1:0] ^ {DIGIT{binv_r}};
        s       = '0;
        cy      = carry_r;
        cin_msb = 1'b0;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]    = ad[i] ^ bd[i] ^ cy;
            cin_msb = cy;
            cy      = (ad[i] & bd[i]) | (cy & (ad[i] ^ bd[i]));
        end
        case (sel_r)
            2'b00:   dsel = ad & bd;
            2'b01:   dsel = ad | bd;
            default: dsel = s;
        endcase
        set       = s[DIGIT-1] ^ (cin_msb ^ cy);
        res_next  = (res_sh >> DIGIT) | (WIDTH'(dsel) << (WIDTH - DIGIT));
        res_final = (sel_r == 2'b11) ? WIDTH'(set) : res_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            ainv_r   <= 1'b0;
            binv_r   <= 1'b0;
            carry_r  <= 1'b0;
            sel_r    <= 2'b00;
            result_r <= '0;
            cout_r   <= 1'b0;
            ovf_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_sh    <= bus.a;
                        b_sh    <= bus.b;
                        ainv_r  <= bus.ainv;
                        binv_r  <= bus.binv;
                        sel_r   <= bus.select;
                        carry_r <= bus.binv;
                        cnt     <= '0;
                        state   <= RUN;
                        busy_r  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> DIGIT;
                    b_sh    <= b_sh >> DIGIT;
                    res_sh  <= res_next;
                    carry_r <= cy;
                    cnt     <= cnt + CW'(1);
                    // The visible result only changes when the whole word is finished.
                    if (cnt == LAST) begin
                        state    <= DONE;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        result_r <= res_final;
                        cout_r   <= cy;
                        ovf_r    <= cin_msb ^ cy;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.result   = result_r;
    assign bus.cout     = cout_r;
    assign bus.overflow = ovf_r;
    assign bus.zero     = (result_r == '0);
endmodule

// File: tb/tb_serial_alu.sv
// Directed bench for serial_alu: DIGIT=1 and DIGIT=4 instances, hand-computed results, flags and edge counts.
module tb_serial_alu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    serial_alu_if #(.WIDTH(32)) b0 ();
    serial_alu_if #(.WIDTH(32)) b4 ();

    serial_alu #(.WIDTH(32), .DIGIT(1)) dut1 (.clk(clk), .rst(rst), .bus(b0));
    serial_alu #(.WIDTH(32), .DIGIT(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run32(input logic [31:0] xa, input logic [31:0] xb, input logic ai,
                         input logic bi, input logic [1:0] sel, output int edges);
        @(negedge clk);
        b0.a = xa; b0.b = xb; b0.ainv = ai; b0.binv = bi; b0.select = sel; b0.start = 1'b1;
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
            b0.start = 1'b0;
        end while (!b0.done && edges < 200);
    endtask

    initial begin
        int  e;
        int  seen;
        b0.start = 0; b0.a = 0; b0.b = 0; b0.ainv = 0; b0.binv = 0; b0.select = 0;
        b4.start = 0; b4.a = 0; b4.b = 0; b4.ainv = 0; b4.binv = 0; b4.select = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",   32'(b0.busy),   32'd0);
        chk("rst_done",   32'(b0.done),   32'd0);
        chk("rst_result", b0.result,      32'd0);
        chk("rst_zero",   32'(b0.zero),   32'd1);
        @(negedge clk);
        rst = 1'b0;

        // signed overflow on ADD
        run32(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 2'b10, e);
        chk("add_edges",  32'(e),            32'd33);
        chk("add_result", b0.result,         32'h80000000);
        chk("add_ovf",    32'(b0.overflow),  32'd1);
        chk("add_cout",   32'(b0.cout),      32'd0);
        chk("add_zero",   32'(b0.zero),      32'd0);
        @(posedge clk); #1;
        chk("done_pulse", 32'(b0.done),      32'd0);

        run32(32'd5, 32'd5, 1'b0, 1'b1, 2'b10, e);
        chk("sub_result", b0.result,         32'd0);
        chk("sub_zero",   32'(b0.zero),      32'd1);
        chk("sub_cout",   32'(b0.cout),      32'd1);
        chk("sub_ovf",    32'(b0.overflow),  32'd0);

        run32(32'hFFFFFFFF, 32'd1, 1'b0, 1'b1, 2'b11, e);
        chk("slt_lt",     b0.result,         32'd1);
        chk("slt_lt_cout", 32'(b0.cout),     32'd1);
        run32(32'd1, 32'hFFFFFFFF, 1'b0, 1'b1, 2'b11, e);
        chk("slt_ge",     b0.result,         32'd0);
        chk("slt_ge_zero", 32'(b0.zero),     32'd1);

        run32(32'h0F0F0F0F, 32'h00FF00FF, 1'b1, 1'b1, 2'b00, e);
        chk("nor_result", b0.result,         32'hF000F000);
        chk("nor_cout",   32'(b0.cout),      32'd1);
        chk("nor_ovf",    32'(b0.overflow),  32'd0);

        run32(32'h12340000, 32'h00005678, 1'b0, 1'b0, 2'b01, e);
        chk("or_result",  b0.result,         32'h12345678);

        // start pulsed mid-RUN with different operands must be ignored
        @(negedge clk);
        b0.a = 32'd1; b0.b = 32'd2; b0.ainv = 0; b0.binv = 0; b0.select = 2'b10; b0.start = 1'b1;
        e = 0;
        do begin
            @(posedge clk); #1;
            e++;
            b0.start = (e == 5);
            if (e == 5) begin b0.a = 32'd100; b0.b = 32'd100; end
        end while (!b0.done && e < 200);
        chk("midrun_edges",  32'(e),  32'd33);
        chk("midrun_result", b0.result, 32'd3);

        // back-to-back: start held through the done cycle
        run32(32'd10, 32'd20, 1'b0, 1'b0, 2'b10, e);
        chk("b2b_first", b0.result, 32'd30);
        b0.a = 32'd7; b0.b = 32'd8; b0.start = 1'b1;
        e = 0;
        do begin
            @(posedge clk); #1;
            e++;
            b0.start = 1'b0;
            if (e == 2) chk("b2b_hold", b0.result, 32'd30);
            if (e == 2) chk("b2b_busy", 32'(b0.busy), 32'd1);
        end while (!b0.done && e < 200);
        chk("b2b_edges",  32'(e),    32'd33);
        chk("b2b_result", b0.result, 32'd15);

        // reset in the middle of an operation
        @(negedge clk);
        b0.a = 32'h55; b0.b = 32'h11; b0.select = 2'b10; b0.start = 1'b1;
        @(posedge clk); #1;
        b0.start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy",   32'(b0.busy), 32'd0);
        chk("arst_done",   32'(b0.done), 32'd0);
        chk("arst_result", b0.result,    32'd0);
        chk("arst_zero",   32'(b0.zero), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (b0.done) seen++;
        end
        chk("arst_no_done", 32'(seen), 32'd0);
        run32(32'd3, 32'd4, 1'b0, 1'b0, 2'b10, e);
        chk("post_rst_edges",  32'(e),    32'd33);
        chk("post_rst_result", b0.result, 32'd7);

        // DIGIT=4 instance
        @(negedge clk);
        b4.a = 32'h12345678; b4.b = 32'h11111111; b4.ainv = 0; b4.binv = 0; b4.select = 2'b10;
        b4.start = 1'b1;
        e = 0;
        do begin
            @(posedge clk); #1;
            e++;
            b4.start = 1'b0;
        end while (!b4.done && e < 200);
        chk("d4_edges",  32'(e),        32'd9);
        chk("d4_result", b4.result,     32'h23456789);
        chk("d4_cout",   32'(b4.cout),  32'd0);
        chk("d4_zero",   32'(b4.zero),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
